instr_prefetch_buffer: RTL and testbench

- Instruction-side stage directly upstream of the core's fetch port.
- Prefetches sequential words from a wait-state instruction memory over a req/gnt/rvalid bus.
- Holds fetched words in a small address-tagged FIFO and presents the word matching the core's requested PC with a valid flag.
- On a PC mismatch (jump, taken branch), flushes the FIFO and refetches from the new PC, discarding any in-flight response.

---
 rtl/ifb_pkg.sv | 22 ++
 rtl/instr_prefetch_buffer_if.sv | 33 +++
 rtl/ifb_fifo.sv | 57 +++++
 rtl/instr_prefetch_buffer.sv | 131 +++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ifb_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifb_state_e;

    // One buffered instruction: word-aligned fetch address plus its data.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ifb_entry_t;

endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Core fetch port and instruction-memory bus of the prefetch buffer.
interface instr_prefetch_buffer_if;
    import ifb_pkg::*;

    logic [ADDR_W-1:0] core_addr_i;
    logic              core_rd_i;
    logic              core_ack_i;
    logic [DATA_W-1:0] core_data_o;
    logic              core_valid_o;
    logic              redirect_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    // Prefetch buffer side.
    modport slave (
        input  core_addr_i, core_rd_i, core_ack_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output core_data_o, core_valid_o, redirect_o,
        output mem_addr_o, mem_req_o
    );

    // Core and memory side.
    modport master (
        output core_addr_i, core_rd_i, core_ack_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  core_data_o, core_valid_o, redirect_o,
        input  mem_addr_o, mem_req_o
    );

endinterface

// File: rtl/ifb_fifo.sv
// Address-tagged instruction FIFO with flush and same-cycle push/pop.
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  ifb_entry_t             wr_entry,
    output ifb_entry_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifb_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with tagged buffer and PC-mismatch redirect.
module instr_prefetch_buffer
    import ifb_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    instr_prefetch_buffer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    ifb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              discard_q, discard_d;

    ifb_entry_t        fifo_head;
    ifb_entry_t        wr_entry;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_after;
    logic              fifo_empty;
    logic              fifo_full;

    logic [ADDR_W-1:0] core_word;
    logic [ADDR_W-1:0] exp_pc;
    logic              hit;
    logic              miss;
    logic              push;
    logic              pop;

    // Every stored and expected address is word aligned, so compare whole words.
    assign core_word = bus.core_addr_i & ~ADDR_W'(WORD_BYTES - 1);

    always_comb begin
        if (!fifo_empty)                        exp_pc = fifo_head.addr;
        else if (state_q == WAIT && !discard_q) exp_pc = out_addr_q;
        else                                    exp_pc = fetch_pc_q;
    end

    assign hit      = bus.core_rd_i && !fifo_empty && (fifo_head.addr == core_word);
    assign miss     = bus.core_rd_i && (core_word != exp_pc);
    assign pop      = hit && bus.core_ack_i;
    assign push     = (state_q == WAIT) && bus.mem_rvalid_i && !discard_q && !miss;
    assign wr_entry = '{addr: out_addr_q, data: bus.mem_rdata_i};

    // Occupancy after this cycle, used to decide whether to issue another fetch.
    assign count_after = miss ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));

    ifb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .push     (push),
        .pop      (pop),
        .flush    (miss),
        .wr_entry (wr_entry),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            out_addr_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_addr_q <= out_addr_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
        end
    end

    // A redirect during an outstanding fetch marks its response for discard.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_addr_d = out_addr_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;

        if (miss) fetch_pc_d = core_word;

        unique case (state_q)
            IDLE: begin
                if (!fifo_full) begin
                    state_d    = REQ;
                    mem_addr_d = fetch_pc_d;
                end
            end
            REQ: begin
                if (miss) discard_d = 1'b1;
                if (bus.mem_gnt_i) begin
                    state_d    = WAIT;
                    out_addr_d = mem_addr_q;
                    if (!miss && !discard_q) fetch_pc_d = mem_addr_q + ADDR_W'(WORD_BYTES);
                end
            end
            WAIT: begin
                if (miss) discard_d = 1'b1;
                if (bus.mem_rvalid_i) begin
                    discard_d = 1'b0;
                    if (count_after < CNT_W'(DEPTH)) begin
                        state_d    = REQ;
                        mem_addr_d = fetch_pc_d;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.core_data_o  = fifo_empty ? '0 : fifo_head.data;
    assign bus.core_valid_o = hit;
    assign bus.redirect_o   = miss;
    assign bus.mem_req_o    = (state_q == REQ);
    assign bus.mem_addr_o   = mem_addr_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed self-checking bench for instr_prefetch_buffer with a small memory responder.
module tb_instr_prefetch_buffer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_prefetch_buffer_if bus ();

    instr_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    bit          gnt_en = 1'b1;
    int          rsp_lat = 0;
    bit          pend = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] grant_q [$];
    bit          saw_redir = 1'b0;
    int          lat;
    int          n0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: grants per gnt_en, answers rsp_lat cycles after the minimum one-cycle latency.
    initial begin
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid_i = 1'b0;
            if (pend) begin
                if (pend_wait == 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            bus.mem_gnt_i = gnt_en;
            if (bus.mem_req_o && gnt_en) begin
                pend      = 1'b1;
                pend_wait = rsp_lat;
                pend_addr = bus.mem_addr_o;
                grant_q.push_back(bus.mem_addr_o);
            end
        end
    end

    task automatic do_reset(input bit gnt, input int rlat);
        @(negedge clk);
        rst_n           = 1'b0;
        bus.core_rd_i   = 1'b0;
        bus.core_ack_i  = 1'b0;
        bus.core_addr_i = '0;
        gnt_en          = gnt;
        rsp_lat         = rlat;
        repeat (3) @(negedge clk);
        grant_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                         input string tag, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            bus.core_rd_i   = 1'b1;
            bus.core_addr_i = addr;
            bus.core_ack_i  = 1'b1;
            #1;
            if (bus.redirect_o) saw_redir = 1'b1;
            if (bus.core_valid_o) begin
                got = 1'b1;
                cyc = i + 1;
            end
        end
        check_eq({tag, "_valid"}, 32'(got), 32'd1);
        if (got) check_eq({tag, "_data"}, bus.core_data_o, exp_data);
        @(posedge clk);
        #1;
        bus.core_rd_i  = 1'b0;
        bus.core_ack_i = 1'b0;
    endtask

    task automatic wait_log(input int n, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (grant_q.size() >= n) ok = 1'b1;
        end
        check_eq(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.core_rd_i   = 1'b0;
        bus.core_ack_i  = 1'b0;
        bus.core_addr_i = '0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req",   32'(bus.mem_req_o),    32'd0);
        check_eq("rst_addr",  bus.mem_addr_o,        RST_PC);
        check_eq("rst_valid", 32'(bus.core_valid_o), 32'd0);
        check_eq("rst_data",  bus.core_data_o,       32'd0);
        check_eq("rst_redir", 32'(bus.redirect_o),   32'd0);

        // Sequential fetch with zero-wait memory
        do_reset(1'b1, 0);
        saw_redir = 1'b0;
        fetch(32'h0, mem_word(32'h0), "t1_w0", lat);
        check_eq("t1_first_latency", 32'(lat), 32'd3);
        fetch(32'h4, mem_word(32'h4), "t1_w4", lat);
        check_eq("t1_steady_latency", 32'(lat), 32'd2);
        fetch(32'h8, mem_word(32'h8), "t1_w8", lat);
        check_eq("t1_no_redirect", 32'(saw_redir), 32'd0);

        // Prefetch stops when full; one pop frees exactly one slot
        do_reset(1'b1, 0);
        repeat (20) @(negedge clk);
        #1;
        check_eq("t2_req_count", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("t2_req_addr", grant_q[i], 32'(i * 4));
        check_eq("t2_full_no_req", 32'(bus.mem_req_o), 32'd0);
        @(negedge clk);
        bus.core_rd_i   = 1'b1;
        bus.core_addr_i = 32'h0;
        bus.core_ack_i  = 1'b1;
        #1;
        check_eq("t2_head_valid", 32'(bus.core_valid_o), 32'd1);
        check_eq("t2_head_data",  bus.core_data_o,       mem_word(32'h0));
        @(posedge clk);
        #1;
        bus.core_rd_i  = 1'b0;
        bus.core_ack_i = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("t2_refill_count", 32'(grant_q.size()), 32'd5);
        check_eq("t2_refill_addr",  grant_q[4],          32'h10);
        check_eq("t2_refull_no_req", 32'(bus.mem_req_o), 32'd0);

        // Request held stable while grant is withheld
        do_reset(1'b0, 0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            #1;
            check_eq("t3_req_held",  32'(bus.mem_req_o), 32'd1);
            check_eq("t3_addr_held", bus.mem_addr_o,     RST_PC);
        end
        check_eq("t3_no_early_gnt", 32'(grant_q.size()), 32'd0);
        gnt_en = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t3_gnt_cycle_req", 32'(bus.mem_req_o), 32'd1);
        check_eq("t3_gnt_taken", 32'(grant_q.size()), 32'd1);
        @(negedge clk);
        #1;
        check_eq("t3_req_dropped", 32'(bus.mem_req_o), 32'd0);
        fetch(32'h0, mem_word(32'h0), "t3_w0", lat);

        // Redirect while waiting for the 0x8 response
        do_reset(1'b1, 1);
        wait_log(3, "t4_reach_0x8");
        @(negedge clk);
        bus.core_rd_i   = 1'b1;
        bus.core_addr_i = 32'h103;
        bus.core_ack_i  = 1'b0;
        #1;
        check_eq("t4_redirect",    32'(bus.redirect_o),   32'd1);
        check_eq("t4_redir_valid", 32'(bus.core_valid_o), 32'd0);
        @(negedge clk);
        #1;
        check_eq("t4_redirect_pulse", 32'(bus.redirect_o),   32'd0);
        check_eq("t4_wait_valid",     32'(bus.core_valid_o), 32'd0);
        wait_log(4, "t4_refetch");
        check_eq("t4_refetch_addr", grant_q[3], 32'h100);
        fetch(32'h103, mem_word(32'h100), "t4_w100", lat);

        // Redirect coinciding with rvalid
        do_reset(1'b1, 0);
        wait_log(1, "t5_first_gnt");
        @(negedge clk);
        bus.core_rd_i   = 1'b1;
        bus.core_addr_i = 32'h40;
        #1;
        check_eq("t5_redirect", 32'(bus.redirect_o),   32'd1);
        check_eq("t5_valid",    32'(bus.core_valid_o), 32'd0);
        @(negedge clk);
        #1;
        check_eq("t5_redirect_pulse", 32'(bus.redirect_o),   32'd0);
        check_eq("t5_empty_valid",    32'(bus.core_valid_o), 32'd0);
        check_eq("t5_empty_data",     bus.core_data_o,       32'd0);
        check_eq("t5_next_req",       32'(bus.mem_req_o),    32'd1);
        check_eq("t5_next_addr",      bus.mem_addr_o,        32'h40);
        bus.core_rd_i = 1'b0;

        // Reset asserted in WAIT; the late response lands during reset
        do_reset(1'b1, 1);
        wait_log(1, "t6_first_gnt");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_eq("t6_rst_req",   32'(bus.mem_req_o),    32'd0);
        check_eq("t6_rst_addr",  bus.mem_addr_o,        RST_PC);
        check_eq("t6_rst_valid", 32'(bus.core_valid_o), 32'd0);
        check_eq("t6_rst_data",  bus.core_data_o,       32'd0);
        check_eq("t6_rst_redir", 32'(bus.redirect_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = grant_q.size();
        fetch(RST_PC, mem_word(RST_PC), "t6_w0", lat);
        check_eq("t6_latency", 32'(lat), 32'd4);
        check_eq("t6_first_req", grant_q[n0], RST_PC);

        // Fetch address wraps from the top of memory to zero
        do_reset(1'b1, 0);
        bus.core_rd_i   = 1'b1;
        bus.core_addr_i = 32'hFFFF_FFFC;
        #1;
        check_eq("t7_redirect", 32'(bus.redirect_o), 32'd1);
        fetch(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), "t7_wtop", lat);
        fetch(32'h0, mem_word(32'h0), "t7_wrap", lat);
        check_eq("t7_req_top",  grant_q[0], 32'hFFFF_FFFC);
        check_eq("t7_req_wrap", grant_q[1], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
